// File: rtl/picoblaze_io_hub_if.sv
// Processor-side port bus of the pacoblaze3 core: port address, write data,
// read data and the interrupt/acknowledge pair.
interface picoblaze_io_hub_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/picoblaze_io_hub.sv
// I/O and interrupt hub for pacoblaze3: registered read mux, output byte
// registers with write pulses, and an edge-trapping interrupt controller.
module picoblaze_io_hub #(
    parameter int         NUM_IN_BYTES  = 4,
    parameter int         NUM_OUT_BYTES = 2,
    parameter int         NUM_IRQ       = 4,
    parameter logic [7:0] IN_BASE       = 8'h00,
    parameter logic [7:0] OUT_BASE      = 8'h80
) (
    input  logic                       clk,
    input  logic                       reset,
    picoblaze_io_hub_if.slave          bus,
    input  logic [8*NUM_IN_BYTES-1:0]  input_data,
    input  logic [NUM_IRQ-1:0]         irq_in,
    output logic [8*NUM_OUT_BYTES-1:0] out_data,
    output logic [NUM_OUT_BYTES-1:0]   out_wr
);
    localparam logic [7:0] ADDR_PEND = 8'hF0;
    localparam logic [7:0] ADDR_MASK = 8'hF1;
    localparam logic [7:0] ADDR_CLR  = 8'hF2;

    logic [7:0]                 r_in_port;
    logic                       r_interrupt;
    logic [8*NUM_OUT_BYTES-1:0] r_out_data;
    logic [NUM_OUT_BYTES-1:0]   r_out_wr;
    logic [NUM_IRQ-1:0]         r_mask;
    logic [NUM_IRQ-1:0]         r_pending;
    logic [NUM_IRQ-1:0]         r_s1;
    logic [NUM_IRQ-1:0]         r_s2;
    logic [NUM_IRQ-1:0]         r_s3;

    logic [7:0]         w_rd_data;
    logic               w_wr_mask;
    logic               w_wr_clr;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_ack_vec;
    logic [NUM_IRQ-1:0] w_ack_pick;
    logic [NUM_IRQ-1:0] w_clr_vec;

    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NUM_IN_BYTES; i++) begin
            if (bus.port_id == 8'(IN_BASE + i))
                w_rd_data = input_data[8*i +: 8];
        end
        if (bus.port_id == ADDR_PEND)
            w_rd_data = 8'(r_pending);
        if (bus.port_id == ADDR_MASK)
            w_rd_data = 8'(r_mask);
    end

    assign w_wr_mask  = bus.write_strobe && (bus.port_id == ADDR_MASK);
    assign w_wr_clr   = bus.write_strobe && (bus.port_id == ADDR_CLR);
    assign w_rise     = r_s2 & ~r_s3;
    // Isolate the lowest set bit of the unmasked pending vector (pre-clear value).
    assign w_ack_vec  = r_pending & r_mask;
    assign w_ack_pick = w_ack_vec & (~w_ack_vec + NUM_IRQ'(1));
    assign w_clr_vec  = (w_wr_clr ? bus.out_port[NUM_IRQ-1:0] : '0)
                      | (bus.interrupt_ack ? w_ack_pick : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_port   <= 8'h00;
            r_interrupt <= 1'b0;
            r_out_data  <= '0;
            r_out_wr    <= '0;
            r_mask      <= '0;
            r_pending   <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
        end else begin
            r_in_port   <= w_rd_data;
            r_interrupt <= |(r_pending & r_mask);
            r_s1        <= irq_in;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            // A rise landing on the same edge as a clear wins, so no event is lost.
            r_pending   <= (r_pending & ~w_clr_vec) | w_rise;
            if (w_wr_mask)
                r_mask <= bus.out_port[NUM_IRQ-1:0];
            r_out_wr <= '0;
            for (int j = 0; j < NUM_OUT_BYTES; j++) begin
                if (bus.write_strobe && (bus.port_id == 8'(OUT_BASE + j))) begin
                    r_out_data[8*j +: 8] <= bus.out_port;
                    r_out_wr[j]          <= 1'b1;
                end
            end
        end
    end

    assign bus.in_port   = r_in_port;
    assign bus.interrupt = r_interrupt;
    assign out_data      = r_out_data;
    assign out_wr        = r_out_wr;
endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Directed bench for picoblaze_io_hub with default parameters.
module tb_picoblaze_io_hub;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] input_data;
    logic [3:0]  irq_in;
    logic [15:0] out_data;
    logic [1:0]  out_wr;
    int          n_cmp = 0;
    int          n_bad = 0;

    picoblaze_io_hub_if bus();

    picoblaze_io_hub dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .input_data (input_data),
        .irq_in     (irq_in),
        .out_data   (out_data),
        .out_wr     (out_wr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id      = addr;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        input_data        = 32'h0;
        irq_in            = 4'h0;
        bus.port_id       = 8'h00;
        bus.out_port      = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.interrupt_ack = 1'b0;
        tick();
        tick();
        chk("rst_in_port", bus.in_port, 8'h00);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_wr", out_wr, 2'b00);
        chk("rst_interrupt", bus.interrupt, 1'b0);
        reset = 1'b0;

        // read sweep
        input_data  = 32'hDEADBEEF;
        bus.port_id = 8'h00; tick(); chk("rd_00", bus.in_port, 8'hEF);
        bus.port_id = 8'h01; tick(); chk("rd_01", bus.in_port, 8'hBE);
        bus.port_id = 8'h02; tick(); chk("rd_02", bus.in_port, 8'hAD);
        bus.port_id = 8'h03; tick(); chk("rd_03", bus.in_port, 8'hDE);
        bus.port_id = 8'h04; tick(); chk("rd_04_unmapped", bus.in_port, 8'h00);
        bus.port_id = 8'h55; tick(); chk("rd_55_unmapped", bus.in_port, 8'h00);
        bus.port_id = 8'hF0; tick(); chk("rd_pending_rst", bus.in_port, 8'h00);

        // output writes
        wr(8'h81, 8'hA5);
        bus.port_id = 8'h55;
        chk("wr81_data", out_data, 16'hA500);
        chk("wr81_pulse", out_wr, 2'b10);
        tick();
        chk("wr81_pulse_end", out_wr, 2'b00);
        chk("wr81_data_hold", out_data, 16'hA500);
        bus.port_id = 8'h80; bus.out_port = 8'h11; bus.write_strobe = 1'b1;
        tick();
        chk("b2b_pulse1", out_wr, 2'b01);
        bus.out_port = 8'h22;
        tick();
        chk("b2b_pulse2", out_wr, 2'b01);
        chk("b2b_data", out_data, 16'hA522);
        bus.write_strobe = 1'b0;
        tick();
        chk("b2b_pulse_end", out_wr, 2'b00);
        wr(8'h82, 8'hFF);
        chk("wr_unmapped_data", out_data, 16'hA522);
        chk("wr_unmapped_pulse", out_wr, 2'b00);

        // mask and interrupt latency
        wr(8'hF1, 8'h04);
        bus.port_id = 8'hF1; tick(); chk("rd_mask", bus.in_port, 8'h04);
        bus.port_id = 8'hF0;
        irq_in = 4'b0100;
        tick();                          // edge n
        tick();                          // edge n+1
        irq_in = 4'b0000;
        tick();                          // edge n+2: pending set
        chk("lat_int_n2", bus.interrupt, 1'b0);
        tick();                          // edge n+3
        chk("lat_pend_n3", bus.in_port, 8'h04);
        chk("lat_int_n3", bus.interrupt, 1'b1);
        irq_in = 4'b0010;
        tick(); tick();
        irq_in = 4'b0000;
        tick(); tick();
        chk("pend_0110", bus.in_port, 8'h06);
        chk("int_still_1", bus.interrupt, 1'b1);
        wr(8'hF2, 8'h04);
        bus.port_id = 8'hF0;
        tick();
        chk("clr_pend_0010", bus.in_port, 8'h02);
        chk("masked_no_int", bus.interrupt, 1'b0);
        wr(8'hF1, 8'h0F);
        tick();
        chk("unmask_int", bus.interrupt, 1'b1);

        // ack priority
        bus.port_id = 8'hF0;
        irq_in = 4'b1000;
        tick(); tick();
        irq_in = 4'b0000;
        tick(); tick();
        chk("pend_1010", bus.in_port, 8'h0A);
        bus.interrupt_ack = 1'b1; tick(); bus.interrupt_ack = 1'b0;
        tick();
        chk("ack1_pend", bus.in_port, 8'h08);
        chk("ack1_int", bus.interrupt, 1'b1);
        bus.interrupt_ack = 1'b1; tick(); bus.interrupt_ack = 1'b0;
        tick();
        chk("ack2_pend", bus.in_port, 8'h00);
        chk("ack2_int", bus.interrupt, 1'b0);

        // set-wins collision
        wr(8'hF1, 8'h01);
        bus.port_id = 8'hF0;
        irq_in = 4'b0001;
        tick(); tick();
        irq_in = 4'b0000;
        tick(); tick();
        chk("sw_pend_pre", bus.in_port, 8'h01);
        irq_in = 4'b0001;
        tick(); tick();
        irq_in = 4'b0000;
        wr(8'hF2, 8'h01);                // same edge as rise detection
        bus.port_id = 8'hF0;
        tick();
        chk("set_wins", bus.in_port, 8'h01);
        chk("set_wins_int", bus.interrupt, 1'b1);
        wr(8'hF2, 8'h01);
        bus.port_id = 8'hF0;
        tick();
        chk("w1c_clear", bus.in_port, 8'h00);

        // reset mid-operation
        wr(8'hF1, 8'h0F);
        bus.port_id = 8'hF0;
        irq_in = 4'b0011;
        tick(); tick();
        irq_in = 4'b0000;
        tick(); tick();
        chk("mid_pend_0011", bus.in_port, 8'h03);
        wr(8'h80, 8'h5A);
        chk("mid_pulse", out_wr, 2'b01);
        reset  = 1'b1;
        irq_in = 4'b1000;
        bus.port_id = 8'hF0;
        tick();
        reset = 1'b0;
        chk("mid_rst_in_port", bus.in_port, 8'h00);
        chk("mid_rst_out_data", out_data, 16'h0000);
        chk("mid_rst_out_wr", out_wr, 2'b00);
        chk("mid_rst_int", bus.interrupt, 1'b0);
        tick(); tick(); tick();          // third edge after release sets pending
        chk("rel_pend_not_yet", bus.in_port, 8'h00);
        tick();
        chk("rel_pend_1000", bus.in_port, 8'h08);
        chk("rel_int_masked", bus.interrupt, 1'b0);
        wr(8'hF2, 8'h08);
        bus.port_id = 8'hF0;
        tick(); tick(); tick(); tick();
        chk("held_no_repeat", bus.in_port, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
